// File: rtl/cpu_regs_pkg.sv
// Shared constants and types for the CPU register file and its serial dump engine.
package cpu_regs_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned GEN_REGS  = 8;
  localparam int unsigned SPEC_REGS = 3;

  // Special registers follow the general registers in the flat index space.
  localparam int unsigned IDX_SP = GEN_REGS;
  localparam int unsigned IDX_IH = GEN_REGS + 1;
  localparam int unsigned IDX_T  = GEN_REGS + 2;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Dump sequencer: walks every register index once over a valid/ready stream.
module reg_dump_ctrl #(
  parameter int unsigned NREGS = 11,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             busy_o,
  output logic             done_o
);
  import cpu_regs_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; flag outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start_i) begin
          state_d = DUMP_SEND;
          idx_d   = '0;
        end
      end
      DUMP_SEND: begin
        if (ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DUMP_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DUMP_DONE: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
    valid_d = (state_d == DUMP_SEND);
    busy_d  = (state_d != DUMP_IDLE);
    done_d  = (state_d == DUMP_DONE);
  end

  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/reg_file_dump.sv
// CPU register file: two bypassed combinational read ports, one write port,
// and a serial dump stream of all registers for the debug display.
module reg_file_dump #(
  parameter int unsigned DATA_W    = cpu_regs_pkg::DATA_W,
  parameter int unsigned GEN_REGS  = cpu_regs_pkg::GEN_REGS,
  parameter int unsigned SPEC_REGS = cpu_regs_pkg::SPEC_REGS,
  parameter bit          ZERO_R0   = 1'b0,
  localparam int unsigned IDX_W    = $clog2(GEN_REGS + SPEC_REGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              regWrite,
  input  logic [IDX_W-1:0]  wIdx,
  input  logic [DATA_W-1:0] wData,
  input  logic [IDX_W-1:0]  rIdxA,
  input  logic [IDX_W-1:0]  rIdxB,
  output logic [DATA_W-1:0] rDataA,
  output logic [DATA_W-1:0] rDataB,
  input  logic              dumpStart,
  input  logic              dumpReady,
  output logic              dumpValid,
  output logic [IDX_W-1:0]  dumpIdx,
  output logic [DATA_W-1:0] dumpData,
  output logic              dumpBusy,
  output logic              dumpDone
);
  import cpu_regs_pkg::*;

  localparam int unsigned      NREGS   = GEN_REGS + SPEC_REGS;
  localparam logic [IDX_W:0]   NREGS_L = (IDX_W + 1)'(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_legal_c;

  // Index 0 is a hard zero when ZERO_R0 is set; out-of-range indices are never storage.
  function automatic logic idx_live(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NREGS_L) && !(ZERO_R0 && (idx == '0));
  endfunction

  assign wr_legal_c = regWrite && idx_live(wIdx);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_legal_c) begin
      regs_q[wIdx] <= wData;
    end
  end

  // Write-first read ports: a legal same-cycle write to the read index wins.
  always_comb begin
    rDataA = '0;
    if (wr_legal_c && (wIdx == rIdxA)) begin
      rDataA = wData;
    end else if (idx_live(rIdxA)) begin
      rDataA = regs_q[rIdxA];
    end
  end

  always_comb begin
    rDataB = '0;
    if (wr_legal_c && (wIdx == rIdxB)) begin
      rDataB = wData;
    end else if (idx_live(rIdxB)) begin
      rDataB = regs_q[rIdxB];
    end
  end

  // Dump read mux shows stored contents only, so a pending write appears a beat later.
  always_comb begin
    dumpData = '0;
    if (idx_live(dumpIdx)) begin
      dumpData = regs_q[dumpIdx];
    end
  end

  reg_dump_ctrl #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_dump_ctrl (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (dumpStart),
    .ready_i (dumpReady),
    .valid_o (dumpValid),
    .idx_o   (dumpIdx),
    .busy_o  (dumpBusy),
    .done_o  (dumpDone)
  );

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: reset, bypass reads, range limits, dump streaming,
// stalls, mid-dump reset, and a ZERO_R0 build sharing the same stimulus.
module tb_reg_file_dump;
  import cpu_regs_pkg::*;

  localparam int unsigned N  = GEN_REGS + SPEC_REGS;
  localparam int unsigned IW = $clog2(N);

  logic              CLK = 1'b0;
  logic              RST;
  logic              regWrite;
  logic [IW-1:0]     wIdx;
  logic [DATA_W-1:0] wData;
  logic [IW-1:0]     rIdxA, rIdxB;
  logic [DATA_W-1:0] rDataA, rDataB;
  logic              dumpStart, dumpReady;
  logic              dumpValid, dumpBusy, dumpDone;
  logic [IW-1:0]     dumpIdx;
  logic [DATA_W-1:0] dumpData;

  logic [DATA_W-1:0] z_rDataA, z_rDataB, z_dumpData;
  logic              z_dumpValid, z_dumpBusy, z_dumpDone;
  logic [IW-1:0]     z_dumpIdx;

  logic [DATA_W-1:0] mdl [N];
  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  reg_file_dump #(.ZERO_R0(1'b0)) dut (
    .CLK(CLK), .RST(RST), .regWrite(regWrite), .wIdx(wIdx), .wData(wData),
    .rIdxA(rIdxA), .rIdxB(rIdxB), .rDataA(rDataA), .rDataB(rDataB),
    .dumpStart(dumpStart), .dumpReady(dumpReady), .dumpValid(dumpValid),
    .dumpIdx(dumpIdx), .dumpData(dumpData), .dumpBusy(dumpBusy), .dumpDone(dumpDone)
  );

  reg_file_dump #(.ZERO_R0(1'b1)) u_z (
    .CLK(CLK), .RST(RST), .regWrite(regWrite), .wIdx(wIdx), .wData(wData),
    .rIdxA(rIdxA), .rIdxB(rIdxB), .rDataA(z_rDataA), .rDataB(z_rDataB),
    .dumpStart(1'b0), .dumpReady(1'b0), .dumpValid(z_dumpValid),
    .dumpIdx(z_dumpIdx), .dumpData(z_dumpData), .dumpBusy(z_dumpBusy), .dumpDone(z_dumpDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int idx, input logic [DATA_W-1:0] data);
    regWrite = 1'b1;
    wIdx     = IW'(idx);
    wData    = data;
    tick();
    regWrite = 1'b0;
    if (idx < int'(N)) mdl[idx] = data;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < int'(N); i++) begin
      rIdxA = IW'(i);
      rIdxB = IW'(int'(N) - 1 - i);
      #1;
      chk({tag, "_A"}, 32'(rDataA), 32'(mdl[i]));
      chk({tag, "_B"}, 32'(rDataB), 32'(mdl[int'(N) - 1 - i]));
    end
  endtask

  initial begin
    int exp_idx;
    int cyc;
    RST = 1'b1; regWrite = 1'b0; wIdx = '0; wData = '0;
    rIdxA = '0; rIdxB = '0; dumpStart = 1'b1; dumpReady = 1'b1;
    for (int i = 0; i < int'(N); i++) mdl[i] = '0;
    tick();
    tick();

    // Reset state; dumpStart held high through reset must not launch a dump.
    chk("rst_valid", 32'(dumpValid), 32'd0);
    chk("rst_busy",  32'(dumpBusy),  32'd0);
    chk("rst_done",  32'(dumpDone),  32'd0);
    chk("rst_idx",   32'(dumpIdx),   32'd0);
    chk("z_rst_valid", 32'(z_dumpValid | z_dumpBusy | z_dumpDone), 32'd0);
    chk("z_rst_idx",   32'(z_dumpIdx), 32'd0);
    chk("z_rst_data",  32'(z_dumpData), 32'd0);
    RST = 1'b0; dumpStart = 1'b0;
    read_all("rst_read");

    // Write-first bypass, then stored value.
    regWrite = 1'b1; wIdx = IW'(3); wData = 16'hBEEF; rIdxA = IW'(3); rIdxB = IW'(4);
    #1;
    chk("bypass_A", 32'(rDataA), 32'hBEEF);
    chk("bypass_B_other", 32'(rDataB), 32'h0);
    tick();
    regWrite = 1'b0; mdl[3] = 16'hBEEF;
    #1;
    chk("stored_A", 32'(rDataA), 32'hBEEF);

    // Special registers and out-of-range indices.
    wr(IDX_SP, 16'h1234);
    wr(IDX_T,  16'h00FF);
    rIdxA = IW'(IDX_SP); rIdxB = IW'(IDX_T);
    #1;
    chk("sp_read", 32'(rDataA), 32'h1234);
    chk("t_read",  32'(rDataB), 32'h00FF);
    rIdxA = IW'(11); rIdxB = IW'(15);
    #1;
    chk("oor_read_11", 32'(rDataA), 32'h0);
    chk("oor_read_15", 32'(rDataB), 32'h0);
    regWrite = 1'b1; wIdx = IW'(12); wData = 16'h5A5A; rIdxA = IW'(12);
    #1;
    chk("oor_no_bypass", 32'(rDataA), 32'h0);
    tick();
    regWrite = 1'b0;
    read_all("oor_write");

    // ZERO_R0 build ignores writes to index 0 and never bypasses it.
    regWrite = 1'b1; wIdx = '0; wData = 16'hFFFF; rIdxA = '0; rIdxB = '0;
    #1;
    chk("r0_bypass",   32'(rDataA),   32'hFFFF);
    chk("z_r0_bypass", 32'(z_rDataA), 32'h0);
    tick();
    regWrite = 1'b0; mdl[0] = 16'hFFFF;
    #1;
    chk("r0_stored",   32'(rDataA),   32'hFFFF);
    chk("z_r0_stored", 32'(z_rDataB), 32'h0);

    // Pattern load then full-speed dump.
    for (int i = 0; i < int'(N); i++) wr(i, 16'(i) * 16'h0101);
    read_all("load");
    dumpReady = 1'b1; dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      chk("d1_valid", 32'(dumpValid), 32'd1);
      chk("d1_idx",   32'(dumpIdx),   32'(k));
      chk("d1_data",  32'(dumpData),  32'(mdl[k]));
      chk("d1_done",  32'(dumpDone),  32'd0);
      tick();
    end
    chk("d1_done_pulse", 32'(dumpDone),  32'd1);
    chk("d1_done_valid", 32'(dumpValid), 32'd0);
    chk("d1_done_busy",  32'(dumpBusy),  32'd1);
    tick();
    chk("d1_after_done", 32'(dumpDone),  32'd0);
    chk("d1_after_busy", 32'(dumpBusy),  32'd0);

    // Stalled dump with ready pattern 1,0,0,1 and an ignored mid-dump start.
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < int'(N) && cyc < 60) begin
      dumpReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      dumpStart = (cyc == 5);
      #1;
      chk("d2_valid", 32'(dumpValid), 32'd1);
      chk("d2_idx",   32'(dumpIdx),   32'(exp_idx));
      chk("d2_data",  32'(dumpData),  32'(mdl[exp_idx]));
      chk("d2_done",  32'(dumpDone),  32'd0);
      tick();
      if (dumpReady) exp_idx++;
      cyc++;
    end
    dumpStart = 1'b0; dumpReady = 1'b1;
    chk("d2_beats", 32'(exp_idx), 32'(N));
    chk("d2_done_pulse", 32'(dumpDone), 32'd1);
    tick();
    chk("d2_after_done", 32'(dumpDone), 32'd0);
    chk("d2_after_busy", 32'(dumpBusy), 32'd0);
    tick();
    chk("d2_no_requeue", 32'(dumpValid), 32'd0);

    // Reset during beat 5, overriding a concurrent write.
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    repeat (5) tick();
    chk("d3_idx5",   32'(dumpIdx),   32'd5);
    chk("d3_valid5", 32'(dumpValid), 32'd1);
    RST = 1'b1; regWrite = 1'b1; wIdx = IW'(2); wData = 16'hAAAA;
    tick();
    RST = 1'b0; regWrite = 1'b0;
    for (int i = 0; i < int'(N); i++) mdl[i] = '0;
    chk("d3_rst_valid", 32'(dumpValid), 32'd0);
    chk("d3_rst_busy",  32'(dumpBusy),  32'd0);
    chk("d3_rst_done",  32'(dumpDone),  32'd0);
    chk("d3_rst_idx",   32'(dumpIdx),   32'd0);
    tick();
    chk("d3_no_done", 32'(dumpDone), 32'd0);
    read_all("d3_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
- Parametrised successor to the CPU register file: GEN_REGS general registers plus SPEC_REGS special registers (SP, IH, T by default) in one flat index space.
- Provides 2 combinational read ports with write-first bypass and 1 synchronous write port on the single pipeline clock. The negedge half-clock write scheme is removed.
- Replaces the wide flat "show all registers" bus with a serial dump engine: valid/ready streaming, for the board display/debug path.
- Sits in the ID stage; WB drives the write port.

Parameters:
- DATA_W, 16, register width in bits
- GEN_REGS, 8, number of general registers, indices 0..GEN_REGS-1
- SPEC_REGS, 3, number of special registers, indices GEN_REGS..GEN_REGS+SPEC_REGS-1 (SP, IH, T in that order)
- ZERO_R0, 0, 1 = index 0 reads as 0 and ignores writes
- IDX_W, $clog2(GEN_REGS+SPEC_REGS), register index width (derived, not overridden)

Ports:
- CLK  in  1  pipeline clock; all state changes on posedge
- RST  in  1  synchronous, active-high reset
- regWrite  in  1  write enable
- wIdx  in  IDX_W  write index
- wData  in  DATA_W  write data
- rIdxA  in  IDX_W  read index, port A
- rIdxB  in  IDX_W  read index, port B
- rDataA  out  DATA_W  read data, port A (combinational)
- rDataB  out  DATA_W  read data, port B (combinational)
- dumpStart  in  1  pulse: begin a dump of all registers
- dumpReady  in  1  consumer accepts the current beat
- dumpValid  out  1  beat valid
- dumpIdx  out  IDX_W  index of the current beat
- dumpData  out  DATA_W  value of the current beat
- dumpBusy  out  1  dump in progress
- dumpDone  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: all registers = 0. FSM = IDLE. dumpValid = 0, dumpBusy = 0, dumpDone = 0, dumpIdx = 0. RST overrides regWrite and dumpStart in the same cycle.
- Write: on posedge, when regWrite=1 and wIdx < GEN_REGS+SPEC_REGS, reg[wIdx] <= wData.
  - Out-of-range index: write is dropped.
  - ZERO_R0=1 with wIdx=0: write is dropped.
- Read, 0-cycle latency:
  - rDataX = wData when regWrite=1, wIdx==rIdxX and the write is legal (write-first bypass).
  - Otherwise rDataX = reg[rIdxX].
  - Out-of-range index reads 0. ZERO_R0=1 with index 0 reads 0, with no bypass.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: when dumpStart=1, go to SEND with dumpIdx=0. dumpBusy=1 from the next cycle.
  - SEND: dumpValid=1. dumpData = reg[dumpIdx], the stored value with no bypass; a same-cycle write shows on the next beat only if the index has not yet advanced past it. Beat transfers when dumpValid & dumpReady. On transfer: if dumpIdx == GEN_REGS+SPEC_REGS-1, go to DONE; else dumpIdx+1.
  - Holding dumpReady=0 stalls indefinitely. dumpIdx is stable during a stall; dumpData tracks live register contents during a stall.
  - DONE: dumpDone=1 for exactly one cycle, dumpValid=0, then IDLE. dumpBusy stays 1 in DONE and is 0 in IDLE.
  - dumpStart while in SEND or DONE is ignored; there is no queueing.
- Dump never blocks the read or write ports.
- RST mid-dump: returns to IDLE next cycle, no dumpDone pulse, registers cleared.
- Dump length is always GEN_REGS+SPEC_REGS beats; minimum of N+1 cycles from start to done pulse with dumpReady held at 1.

Decomposition:
- Shared package cpu_regs_pkg holds:
  - DATA_W
  - GEN_REGS
  - SPEC_REGS
  - special-register index constants: IDX_SP = GEN_REGS, IDX_IH = GEN_REGS+1, IDX_T = GEN_REGS+2
  - dump FSM state encoding
- One natural sub-module: reg_dump_ctrl (FSM, index counter, handshake). It indexes the storage through a third internal read mux.

Test Plan:
- Reset then read every index on both ports -> all 0. dumpValid=0, dumpBusy=0.
- Write 16'hBEEF to idx 3 with rIdxA=3 in the same cycle -> rDataA=16'hBEEF combinationally (bypass). Next cycle, regWrite=0 -> rDataA still 16'hBEEF.
- Write 16'h1234 to IDX_SP (8) and 16'h00FF to IDX_T (10). Read idx 11 -> 0. Write to idx 12 -> no register changes.
- Load reg[i]=i*16'h0101, then pulse dumpStart with dumpReady=1 -> 11 consecutive beats, idx 0..10 with matching data. dumpDone pulses exactly once on the cycle after the beat with idx 10.
- During a dump, toggle dumpReady 1,0,0,1 -> dumpIdx holds across stalls, with no skipped or duplicated indices. A dumpStart pulse mid-dump -> ignored.
- Assert RST during beat idx 5 -> next cycle dumpValid=0, dumpBusy=0, no dumpDone pulse, all registers read 0. ZERO_R0=1 build: write 16'hFFFF to idx 0 -> rDataA(0)=0.
